// File: rtl/mux_channel_scanner_if.sv
// Sample output stream of the channel scanner: sampled mux value plus its
// channel tag, transferred on valid && ready at the rising clock edge.
interface mux_channel_scanner_if;
    logic [3:0] data;
    logic [1:0] ch;
    logic       valid;
    logic       ready;

    // Scanner side: produces data/ch/valid, observes ready.
    modport master (
        output data,
        output ch,
        output valid,
        input  ready
    );

    // Consumer side: observes data/ch/valid, drives ready.
    modport slave (
        input  data,
        input  ch,
        input  valid,
        output ready
    );
endinterface

// File: rtl/mux_channel_scanner.sv
// Round-robin sequencer for an external 4-bit 4-to-1 mux: drives the select
// lines over the enabled channels, waits DWELL cycles for the mux output to
// settle, samples it and offers the sample with its channel tag downstream.
module mux_channel_scanner #(
    parameter int unsigned DWELL = 2    // settle cycles, legal range 1..15
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [3:0]                    ch_mask,
    input  logic [3:0]                    mux_out,
    output logic                          s0,
    output logic                          s1,
    mux_channel_scanner_if.master         out
);

    localparam logic [3:0] CNT_LAST = 4'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [1:0] last_ch;
    logic [1:0] next_ch;

    logic       load_sel;
    logic       cnt_inc;
    logic       take_sample;
    logic       release_out;

    // Next channel: first enabled channel after last_ch, wrapping, with
    // last_ch itself tried last. Walking offsets high-to-low lets the
    // smallest offset overwrite and win.
    always_comb begin
        logic [1:0] cand;
        next_ch = last_ch;
        cand    = last_ch;
        for (int unsigned i = 4; i >= 1; i--) begin
            cand = last_ch + 2'(i);
            if (ch_mask[cand]) begin
                next_ch = cand;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath strobes; an en drop in SETTLE wins over sampling.
    always_comb begin
        state_nxt   = state;
        load_sel    = 1'b0;
        cnt_inc     = 1'b0;
        take_sample = 1'b0;
        release_out = 1'b0;
        unique case (state)
            IDLE: begin
                if (en && (ch_mask != '0)) begin
                    load_sel  = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    take_sample = 1'b1;
                    state_nxt   = HOLD;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            HOLD: begin
                if (out.ready) begin
                    release_out = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Select lines and scan position; selects hold their value while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0      <= 1'b0;
            s1      <= 1'b0;
            last_ch <= 2'd3;
        end else if (load_sel) begin
            {s1, s0} <= next_ch;
            last_ch  <= next_ch;
        end
    end

    // Settle counter, restarted whenever a new channel is selected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load_sel) begin
            cnt <= '0;
        end else if (cnt_inc) begin
            cnt <= cnt + 4'd1;
        end
    end

    // Output sample register: captured at end of settle, held until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out.data  <= '0;
            out.ch    <= '0;
            out.valid <= 1'b0;
        end else if (take_sample) begin
            out.data  <= mux_out;
            out.ch    <= {s1, s0};
            out.valid <= 1'b1;
        end else if (release_out) begin
            out.valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Directed bench for mux_channel_scanner: one DWELL=2 instance exercising
// scan order, masking, backpressure, abort and reset, plus a DWELL=1 instance
// for the short-dwell period. Each instance drives its own 4-to-1 mux model.
module tb_mux_channel_scanner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       en1;
    logic [3:0] ch_mask;
    logic [3:0] ch_mask1;
    logic [3:0] mux_out;
    logic [3:0] mux_out1;
    logic       s0;
    logic       s1;
    logic       s0b;
    logic       s1b;
    logic [3:0] mux_in [4];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mux_channel_scanner_if bus ();
    mux_channel_scanner_if bus1 ();

    mux_channel_scanner #(.DWELL(2)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .ch_mask (ch_mask),
        .mux_out (mux_out),
        .s0      (s0),
        .s1      (s1),
        .out     (bus)
    );

    mux_channel_scanner #(.DWELL(1)) u_dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en1),
        .ch_mask (ch_mask1),
        .mux_out (mux_out1),
        .s0      (s0b),
        .s1      (s1b),
        .out     (bus1)
    );

    // External mux models.
    always_comb begin
        mux_out  = mux_in[{s1, s0}];
        mux_out1 = mux_in[{s1b, s0b}];
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_sample(input string tag, input int exp_n,
                                 input logic [1:0] exp_ch, input logic [3:0] exp_d);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (bus.valid !== 1'b1 && n < 20);
        chk({tag, "_valid"}, 8'(bus.valid), 8'd1);
        chk({tag, "_gap"},   8'(n),         8'(exp_n));
        chk({tag, "_ch"},    8'(bus.ch),    8'(exp_ch));
        chk({tag, "_data"},  8'(bus.data),  8'(exp_d));
        chk({tag, "_sel"},   8'({s1, s0}),  8'(exp_ch));
    endtask

    task automatic expect_sample1(input string tag, input int exp_n,
                                  input logic [1:0] exp_ch, input logic [3:0] exp_d);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (bus1.valid !== 1'b1 && n < 20);
        chk({tag, "_valid"}, 8'(bus1.valid), 8'd1);
        chk({tag, "_gap"},   8'(n),          8'(exp_n));
        chk({tag, "_ch"},    8'(bus1.ch),    8'(exp_ch));
        chk({tag, "_data"},  8'(bus1.data),  8'(exp_d));
    endtask

    initial begin
        int cnt_v;
        mux_in[0] = 4'b1010;
        mux_in[1] = 4'b1111;
        mux_in[2] = 4'b0000;
        mux_in[3] = 4'b0101;
        rst_n      = 1'b1;
        en         = 1'b0;
        en1        = 1'b0;
        ch_mask    = 4'b1111;
        ch_mask1   = 4'b0100;
        bus.ready  = 1'b1;
        bus1.ready = 1'b1;

        // Reset values.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", 8'(bus.valid), 8'd0);
        chk("rst_data",  8'(bus.data),  8'd0);
        chk("rst_ch",    8'(bus.ch),    8'd0);
        chk("rst_sel",   8'({s1, s0}),  8'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        en    = 1'b1;

        // Full scan: 0,1,2,3 then 0 again, one-cycle valid pulses, 4-cycle period.
        expect_sample("scan0", 3, 2'd0, 4'b1010);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk("scan_pulse", 8'(bus.valid), 8'd0);
            expect_sample("scan", 3, 2'(k % 4), mux_in[k % 4]);
        end

        // Masked skip: only channels 1 and 3.
        ch_mask = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            cyc();
            expect_sample("mask", 3, (k % 2 == 0) ? 2'd1 : 2'd3,
                          (k % 2 == 0) ? 4'b1111 : 4'b0101);
        end

        // Backpressure: hold ch0 sample for 10 cycles, then exactly one transfer.
        ch_mask = 4'b1111;
        cyc();
        expect_sample("bp_first", 3, 2'd0, 4'b1010);
        bus.ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk("bp_valid", 8'(bus.valid), 8'd1);
            chk("bp_data",  8'(bus.data),  8'b1010);
            chk("bp_ch",    8'(bus.ch),    8'd0);
            chk("bp_sel",   8'({s1, s0}),  8'd0);
        end
        bus.ready = 1'b1;
        cyc();
        chk("bp_xfer", 8'(bus.valid), 8'd0);
        expect_sample("bp_next", 3, 2'd1, 4'b1111);

        // Abort during the first settle cycle of channel 2.
        cyc();
        chk("abort_rel", 8'(bus.valid), 8'd0);
        cyc();
        chk("abort_sel", 8'({s1, s0}), 8'd2);
        en = 1'b0;
        cnt_v = 0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            if (bus.valid !== 1'b0) cnt_v++;
        end
        chk("abort_novalid", 8'(cnt_v), 8'd0);
        en = 1'b1;
        expect_sample("abort_resume", 3, 2'd3, 4'b0101);

        // Asynchronous reset while a sample is pending.
        bus.ready = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid", 8'(bus.valid), 8'd0);
        chk("arst_data",  8'(bus.data),  8'd0);
        chk("arst_ch",    8'(bus.ch),    8'd0);
        chk("arst_sel",   8'({s1, s0}),  8'd0);
        cyc();
        rst_n     = 1'b1;
        bus.ready = 1'b1;
        expect_sample("arst_first", 3, 2'd0, 4'b1010);

        // Empty mask with en high: nothing produced.
        cyc();
        ch_mask = 4'b0000;
        cnt_v = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (bus.valid !== 1'b0) cnt_v++;
        end
        chk("mask0_novalid", 8'(cnt_v), 8'd0);

        // DWELL=1, single channel 2: sample every 3 cycles.
        en1 = 1'b1;
        expect_sample1("d1_first", 2, 2'd2, 4'b0000);
        expect_sample1("d1_second", 3, 2'd2, 4'b0000);
        expect_sample1("d1_third", 3, 2'd2, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_channel_scanner.md
Name: mux_channel_scanner

Overview:
- Sequencer sitting directly upstream and downstream of the 4-bit 4-to-1 mux datapath.
- Drives the mux select lines s0/s1 round-robin over the enabled channels.
- Waits a programmable settle time, then samples the mux 4-bit output.
- Presents each sample with its channel tag on a valid/ready output handshake.

Parameters:
DWELL, 2, cycles select is held stable before mux output is sampled; legal range 1..15

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  scan enable
ch_mask  input  4  per-channel enable; bit k enables channel k
mux_out  input  4  4-bit output of the external 4-to-1 mux
s0  output  1  mux select LSB, registered
s1  output  1  mux select MSB, registered
data  output  4  sampled mux value
ch  output  2  channel index of data ({s1,s0} at sample time)
valid  output  1  data/ch valid
ready  input  1  downstream accepts data when valid&&ready at rising edge

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: s0=0, s1=0, data=0, ch=0, valid=0, state=IDLE, dwell counter=0, last_ch=3. last_ch=3 makes the first search start at channel 0.
- All outputs are registered. No combinational path from inputs to outputs.
- FSM states: IDLE, SETTLE, HOLD.
- IDLE:
  - If en=1 and ch_mask!=0: pick next = first set mask bit searching last_ch+1, last_ch+2, ... modulo 4 (wraps 3->0; last_ch itself is searched last).
  - At the edge: {s1,s0}<=next, last_ch<=next, cnt<=0, state<=SETTLE.
  - Otherwise stay in IDLE; s0/s1 hold their last value.
- SETTLE:
  - cnt increments each cycle.
  - At the edge where cnt==DWELL-1: data<=mux_out, ch<={s1,s0}, valid<=1, state<=HOLD.
  - valid therefore rises DWELL cycles after s0/s1 change.
- HOLD:
  - valid, data, ch and s0/s1 are held stable.
  - At the edge where ready=1: valid<=0, state<=IDLE.
- Throughput: with ready tied high and one or more channels enabled, one sample every DWELL+2 cycles. DWELL=2 gives a 4-cycle period.
- en deasserted in SETTLE: abort to IDLE at the next edge, no valid produced. last_ch keeps the aborted channel, so the next scan resumes after it.
- en deasserted in HOLD: valid is never retracted; the transfer completes normally, then the block idles.
- ch_mask changes: sampled only in IDLE. A change during SETTLE/HOLD does not affect the current channel.
- ch_mask==0 with en=1: remain in IDLE, no output.
- Single enabled channel: that channel is rescanned every period.
- ready=1 while valid=0: ignored.
- ready held low: block stalls indefinitely in HOLD and drops no data.
- rst_n asserted mid-operation (any state): all registers return to reset values immediately and asynchronously. A pending valid is discarded.
- Deassertion of rst_n is synchronised externally. The first active edge after release is treated as IDLE.

Test Plan:
- Full scan: mux inputs i0=1010, i1=1111, i2=0000, i3=0101; DWELL=2; en=1; ch_mask=1111; ready=1 -> outputs (ch,data) = (0,1010), (1,1111), (2,0000), (3,0101), then (0,1010) again; valid pulses 1 cycle each, 4 cycles apart; {s1,s0} sequence 00, 01, 10, 11.
- Masked skip: ch_mask=1010 -> ch alternates 1, 3, 1, 3 with data 1111, 0101; channels 0 and 2 are never selected.
- Backpressure: ready=0 for 10 cycles after the first valid -> valid, data=1010, ch=0 and s0/s1 stay constant for all 10 cycles; after ready=1, exactly one transfer, and the next sample is ch=1.
- Abort: en dropped during the first SETTLE cycle of ch=2 -> no valid; state IDLE; en=1 again -> next sample is ch=3 with data 0101.
- Reset mid-HOLD: rst_n=0 while valid=1 -> valid=0, data=0, ch=0, s0=s1=0 asynchronously, without waiting for a clock edge; after release with ch_mask=1111 the first sample is ch=0.
- Edge cases: ch_mask=0000 with en=1 -> no valid for 20 cycles. DWELL=1 with ch_mask=0100 -> ch=2, data=0000 every 3 cycles.
